// File: rtl/evt_generator.sv
// evt_generator: programmable single-cycle strobe source, finite burst or continuous; EVT_GENERATOR_PHASE_EN adds a start phase input
module evt_generator #(
  parameter int PERIOD_W = 27,
  parameter int COUNT_W  = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic                abort_in,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic [COUNT_W-1:0]  burst_len_in,
`ifdef EVT_GENERATOR_PHASE_EN
  input  logic [PERIOD_W-1:0] phase_in,
`endif
  output logic                evt_out,
  output logic                busy_out,
  output logic                done_out,
  output logic [COUNT_W-1:0]  pulses_out
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t              r_state;
  logic [PERIOD_W-1:0] r_period, r_tick;
  logic [COUNT_W-1:0]  r_len, r_pulses;
  logic                r_evt, r_busy, r_done;
  logic [PERIOD_W-1:0] w_period, w_start_tick;
  logic [COUNT_W-1:0]  w_pulses_nxt;
  logic                w_wrap;
  assign w_period = period_in == '0 ? PERIOD_W'(1) : period_in;
`ifdef EVT_GENERATOR_PHASE_EN
  assign w_start_tick = phase_in % w_period;
`else
  assign w_start_tick = '0;
`endif
  assign w_wrap       = r_tick == r_period - PERIOD_W'(1);
  assign w_pulses_nxt = r_pulses + COUNT_W'(1);
  assign evt_out      = r_evt;
  assign busy_out     = r_busy;
  assign done_out     = r_done;
  assign pulses_out   = r_pulses;
  // Control FSM: capture on start, tick/pulse counting in RUN, one-cycle DONE status
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_len    <= '0;
      r_tick   <= '0;
      r_pulses <= '0;
      r_evt    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_evt  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_in && !abort_in) begin
          r_state  <= S_RUN;
          r_period <= w_period;
          r_len    <= burst_len_in;
          r_tick   <= w_start_tick;
          r_pulses <= '0;
          r_busy   <= 1'b1;
        end
        S_RUN: if (abort_in) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_tick <= w_wrap ? '0 : r_tick + PERIOD_W'(1);
          if (w_wrap) begin
            r_evt    <= 1'b1;
            r_pulses <= w_pulses_nxt;
            if (r_len != '0 && w_pulses_nxt == r_len) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_evt_generator.sv
// tb_evt_generator: directed and random checks of evt_generator against an edge-arithmetic reference model
module tb_evt_generator;
  localparam int PERIOD_W = 27;
  localparam int COUNT_W  = 16;
  localparam longint INF  = 64'sd1 <<< 60;
  logic                clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, abort_in = 1'b0;
  logic [PERIOD_W-1:0] period_in = '0;
  logic [COUNT_W-1:0]  burst_len_in = '0;
  logic                evt_out, busy_out, done_out;
  logic [COUNT_W-1:0]  pulses_out;
`ifdef EVT_GENERATOR_PHASE_EN
  logic [PERIOD_W-1:0] phase_in = '0;
`endif
  int checks = 0, errors = 0;
  longint e = 0, s = 0, mp = 1, ml = 0, mph = 0, end_e = 0;
  bit started = 0;

  evt_generator #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
    .period_in(period_in), .burst_len_in(burst_len_in),
`ifdef EVT_GENERATOR_PHASE_EN
    .phase_in(phase_in),
`endif
    .evt_out(evt_out), .busy_out(busy_out), .done_out(done_out), .pulses_out(pulses_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  task automatic compare();
    longint m, cnt;
    bit x_evt, x_busy, x_done;
    x_evt  = started && e > s && e < end_e && ((e - s + mph) % mp == 0);
    x_busy = started && e < end_e;
    x_done = started && ml != 0 && e == end_e && end_e == s + ml * mp - mph + 1;
    m   = e < end_e ? e : end_e - 1;
    cnt = started ? ((m - s + mph) / mp) % (64'sd1 <<< COUNT_W) : 0;
    check("evt", longint'(evt_out), longint'(x_evt));
    check("busy", longint'(busy_out), longint'(x_busy));
    check("done", longint'(done_out), longint'(x_done));
    check("pulses", longint'(pulses_out), cnt);
  endtask

  task automatic step(input bit st, input bit ab, input longint per, input longint len, input longint ph);
    start_in = st;
    abort_in = ab;
    period_in = PERIOD_W'(per);
    burst_len_in = COUNT_W'(len);
`ifdef EVT_GENERATOR_PHASE_EN
    phase_in = PERIOD_W'(ph);
`endif
    @(posedge clk_in);
    e++;
    if (!started || e > end_e) begin
      if (st && !ab) begin
        started = 1;
        s = e;
        mp = per == 0 ? 1 : per;
        ml = len;
`ifdef EVT_GENERATOR_PHASE_EN
        mph = ph % mp;
`else
        mph = ph * 0;
`endif
        end_e = ml == 0 ? INF : s + ml * mp - mph + 1;
      end
    end else if (ab && (ml == 0 || e <= s + ml * mp - mph)) end_e = e;
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_evt", longint'(evt_out), 0);
    check("rst_busy", longint'(busy_out), 0);
    check("rst_done", longint'(done_out), 0);
    check("rst_pulses", longint'(pulses_out), 0);
    rst_in = 1'b0;
    idle(2);
    step(1, 0, 4, 3, 0);
    idle(16);
    step(1, 0, 0, 5, 0);
    idle(8);
    step(1, 0, 1, 5, 0);
    idle(8);
    step(1, 0, 3, 0, 0);
    idle(11);
    step(0, 1, 0, 0, 0);
    idle(6);
    step(1, 0, 4, 2, 0);
    step(0, 0, 9, 7, 0);
    step(1, 0, 9, 7, 0);
    step(0, 0, 9, 7, 0);
    step(0, 0, 9, 7, 0);
    step(1, 0, 9, 7, 0);
    idle(8);
    step(1, 1, 2, 2, 0);
    idle(4);
    step(1, 0, 5, 3, 0);
    idle(6);
    #2 rst_in = 1'b1;
    #1;
    check("arst_evt", longint'(evt_out), 0);
    check("arst_busy", longint'(busy_out), 0);
    check("arst_done", longint'(done_out), 0);
    check("arst_pulses", longint'(pulses_out), 0);
    rst_in = 1'b0;
    started = 0;
    step(1, 0, 2, 2, 0);
    idle(7);
`ifdef EVT_GENERATOR_PHASE_EN
    step(1, 0, 8, 3, 5);
    idle(24);
    step(1, 0, 8, 3, 13);
    idle(24);
`endif
    for (int i = 0; i < 1500; i++)
      step($urandom_range(5) == 0, $urandom_range(24) == 0, longint'($urandom_range(6)),
           longint'($urandom_range(5)), longint'($urandom_range(20)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
